mul_share_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 32x32 vedic multiplier (operands a/b in, result/valid_out back) between NREQ requesters in the matrix-multiply datapath.
- Accepts one request at a time, drives the operands, waits for the multiplier's valid, then routes the 64-bit product back to the owning requester.
- Bounded by a timeout so a stalled multiplier cannot hang the matrix engine.

---
 rtl/mul_share_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one DW x DW multiplier between NREQ requesters.
// Latency: accept T, mul_start T+1, capture T+2 (ideal), rsp_valid T+3; timeout rsp at T+TIMEOUT+2.
// Backpressure: req_ready only in IDLE (one op in flight); responses have no backpressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_a/req_b    per-requester request, operands packed at [i*DW +: DW]
//   req_ready                one-hot combinational grant, IDLE only
//   rsp_valid/rsp_result/rsp_err  one-cycle strobe to owner, shared product bus + error flag
//   mul_a/mul_b/mul_start    registered operands and start pulse to the multiplier
//   mul_result/mul_valid     multiplier product and valid_out
//   busy, grant_id, chk_fail status: not IDLE, current/last owner, sticky product check failure
//
// Optional build macro MUL_CHECK_EN: recompute mul_a*mul_b internally and flag mismatches.
module mul_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 32,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [2*DW-1:0]      rsp_result,
  output logic                 rsp_err,
  output logic [DW-1:0]        mul_a,
  output logic [DW-1:0]        mul_b,
  output logic                 mul_start,
  input  logic [2*DW-1:0]      mul_result,
  input  logic                 mul_valid,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 chk_fail
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_WAIT_C = CW'(MIN_WAIT);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic [DW-1:0]   mul_a_q, mul_a_d;
  logic [DW-1:0]   mul_b_q, mul_b_d;
  logic            start_q, start_d;
  logic [2*DW-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_err_q, rsp_err_d;
  logic            chk_fail_q, chk_fail_d;

  // Round-robin pick: scan positions rr_ptr, rr_ptr+1, ... (mod NREQ) and take
  // the first valid requester.
  logic [NREQ-1:0] grant_vec;
  logic            sel_found;
  logic [2:0]      sel_idx;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [3:0]      pos;

  always_comb begin
    grant_vec = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_a     = '0;
    sel_b     = '0;
    pos       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr_q} + 4'(k);
      if (pos >= 4'(NREQ)) pos = pos - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!sel_found && (pos == 4'(i)) && req_valid[i]) begin
          sel_found    = 1'b1;
          grant_vec[i] = 1'b1;
          sel_idx      = 3'(i);
          sel_a        = req_a[i*DW +: DW];
          sel_b        = req_b[i*DW +: DW];
        end
      end
    end
  end

  // Product self-check; in the default build there is no comparator at all.
  logic chk_mismatch;
`ifdef MUL_CHECK_EN
  logic [2*DW-1:0] chk_prod;
  assign chk_prod     = (2*DW)'(mul_a_q) * (2*DW)'(mul_b_q);
  assign chk_mismatch = (chk_prod != mul_result);
`else
  assign chk_mismatch = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    grant_id_d   = grant_id_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    start_d      = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    chk_fail_d   = chk_fail_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          mul_a_d    = sel_a;
          mul_b_d    = sel_b;
          grant_id_d = sel_idx;
          rr_ptr_d   = (sel_idx == 3'(NREQ - 1)) ? 3'd0 : sel_idx + 3'd1;
          cnt_d      = '0;
          start_d    = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // The first MIN_WAIT cycles may still show the previous op's valid.
        if ((cnt_q >= MIN_WAIT_C) && mul_valid) begin
          rsp_result_d = mul_result;
          rsp_err_d    = 1'b0;
          if (chk_mismatch) begin
            rsp_err_d  = 1'b1;
            chk_fail_d = 1'b1;
          end
          state_d = S_RESP;
        end else if (cnt_q == TIMEOUT_C) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      grant_id_q   <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      start_q      <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      chk_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      grant_id_q   <= grant_id_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      start_q      <= start_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      chk_fail_q   <= chk_fail_d;
    end
  end

  // Grants are masked while rst is high so every output reads 0 in reset.
  assign req_ready = ((state_q == S_IDLE) && !rst) ? grant_vec : '0;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state_q == S_RESP) && (grant_id_q == 3'(i));
    end
  end

  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_start  = start_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_id_q;
  assign chk_fail   = chk_fail_q;

endmodule
